// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wr_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [ITER_CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]       acc_q, acc_d;
    logic [XLEN-1:0]       shr_q, shr_d;
    logic [XLEN-1:0]       opb_q, opb_d;
    logic [XLEN-1:0]       hi_q, hi_d;
    logic [XLEN-1:0]       lo_q, lo_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  div_zero_q, div_zero_d;
    logic                  done_q, done_d;
`ifdef MULDIV_FAST_MUL_EN
    logic                  fast_q, fast_d;
`endif

    logic [XLEN:0]         mul_sum, div_shift, div_trial;
    logic [XLEN-1:0]       acc_n, shr_n;
    logic [2*XLEN-1:0]     prod_mag, prod_fix;
    logic [XLEN-1:0]       quo_fix, rem_fix;
    logic                  signed_op, rs_neg, rt_neg;
    logic [XLEN-1:0]       mag_a, mag_b;

    // One core step on magnitudes: shift-add for multiply, restoring step for divide.
    // acc holds product-high / remainder, shr holds multiplier-then-product-low / dividend-then-quotient.
    always_comb begin
        acc_n     = acc_q;
        shr_n     = shr_q;
        mul_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, shr_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opb_q};
        if (is_div_q) begin
            if (!div_trial[XLEN]) begin
                acc_n = div_trial[XLEN-1:0];
                shr_n = {shr_q[XLEN-2:0], 1'b1};
            end else begin
                acc_n = div_shift[XLEN-1:0];
                shr_n = {shr_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_n = mul_sum[XLEN:1];
            shr_n = {mul_sum[0], shr_q[XLEN-1:1]};
        end

        prod_mag = {acc_n, shr_n};
`ifdef MULDIV_FAST_MUL_EN
        if (fast_q) begin
            prod_mag = {{XLEN{1'b0}}, opb_q} * {{XLEN{1'b0}}, shr_q};
        end
`endif
        prod_fix = neg_res_q ? -prod_mag : prod_mag;
        quo_fix  = div_zero_q ? '1 : (neg_res_q ? -shr_n : shr_n);
        rem_fix  = neg_rem_q ? -acc_n : acc_n;
    end

    always_comb begin
        signed_op = ~op[0];
        rs_neg    = signed_op & rs_val[XLEN-1];
        rt_neg    = signed_op & rt_val[XLEN-1];
        mag_a     = rs_neg ? -rs_val : rs_val;
        mag_b     = rt_neg ? -rt_val : rt_val;
    end

    // The last core step happens in FINISH, so busy spans 31 RUN cycles plus FINISH.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        shr_d      = shr_q;
        opb_d      = opb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
        fast_d     = fast_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wr_data;
                if (lo_we) lo_d = wr_data;
                if (start) begin
                    is_div_d   = op[1];
                    neg_res_d  = rs_neg ^ rt_neg;
                    neg_rem_d  = rs_neg;
                    div_zero_d = (rt_val == '0);
                    acc_d      = '0;
                    count_d    = '0;
                    opb_d      = op[1] ? mag_b : mag_a;
                    shr_d      = op[1] ? mag_a : mag_b;
                    state_d    = S_RUN;
`ifdef MULDIV_FAST_MUL_EN
                    fast_d     = ~op[1];
                    if (!op[1]) state_d = S_FINISH;
`endif
                end
            end
            S_RUN: begin
                acc_d   = acc_n;
                shr_d   = shr_n;
                count_d = count_q + ITER_CNT_W'(1);
                if (count_d == ITER_CNT_W'(XLEN - 1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                hi_d    = is_div_q ? rem_fix : prod_fix[2*XLEN-1:XLEN];
                lo_d    = is_div_q ? quo_fix : prod_fix[XLEN-1:0];
                done_d  = 1'b1;
                count_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            shr_q      <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            fast_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            shr_q      <= shr_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
`ifdef MULDIV_FAST_MUL_EN
            fast_q     <= fast_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic reference model.
// Latency expectations follow MULDIV_FAST_MUL_EN when the bench is built with it.
module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    muldiv_unit #(.XLEN(32), .ITER_CNT_W(6)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Results straight from the arithmetic definitions of each op.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] eh, output logic [31:0] el);
        longint p;
        int     sa, sb;
        sa = a;
        sb = b;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin
                p  = longint'(sa) * longint'(sb);
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                p  = longint'({32'b0, a}) * longint'({32'b0, b});
                eh = p[63:32];
                el = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000;
                    eh = 32'h0;
                end else begin
                    el = sa / sb;
                    eh = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
    endtask

    // Launch one op, then follow it to done; optionally pair it with MTLO or harass it while busy.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit mt_with_start);
        logic [31:0] eh, el;
        int          cyc, busy_cnt, done_cyc, exp_done, exp_busy;
        bit          hold_ok;
        ref_model(o, a, b, eh, el);
        exp_done = (FAST && !o[1]) ? 2 : 33;
        exp_busy = (FAST && !o[1]) ? 1 : 32;
        apply_stimulus(o, a, b);
        if (mt_with_start) begin
            lo_we   = 1'b1;
            wr_data = 32'h1357_9BDF;
        end
        step();
        start  = 1'b0;
        lo_we  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        op     = 2'($urandom);
        if (mt_with_start) begin
            lo_m = 32'h1357_9BDF;
            check_output({tag, ".mt_same_cycle"}, lo, lo_m);
        end
        cyc      = 1;
        busy_cnt = 0;
        done_cyc = 0;
        hold_ok  = 1'b1;
        while (done_cyc == 0 && cyc <= 80) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (busy) busy_cnt++;
                if (hi !== hi_m || lo !== lo_m) hold_ok = 1'b0;
                if (disturb) begin
                    start   = 1'b1;
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    wr_data = $urandom;
                end
                step();
                cyc++;
            end
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check_output({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check_output({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check_output({tag, ".hold"}, 32'(hold_ok), 32'd1);
        check_output({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check_output({tag, ".hi"}, hi, eh);
        check_output({tag, ".lo"}, lo, el);
        hi_m = eh;
        lo_m = el;
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  o;
        bit          seen_done;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_val  = '0;
        rt_val  = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wr_data = '0;
        hi_m    = '0;
        lo_m    = '0;
        repeat (3) step();
        check_output("reset.busy", 32'(busy), 32'd0);
        check_output("reset.done", 32'(done), 32'd0);
        check_output("reset.hi", hi, 32'd0);
        check_output("reset.lo", lo, 32'd0);
        reset = 1'b0;
        step();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op("divu_zero", 2'b11, 32'd1234, 32'd0, 1'b0, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_neg_zero", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        step();
        check_output("done_one_cycle", 32'(done), 32'd0);

        lo_we   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        step();
        lo_we = 1'b0;
        lo_m  = 32'hDEAD_BEEF;
        check_output("mtlo.lo", lo, lo_m);
        check_output("mtlo.hi", hi, hi_m);
        hi_we   = 1'b1;
        wr_data = 32'hCAFE_F00D;
        step();
        hi_we = 1'b0;
        hi_m  = 32'hCAFE_F00D;
        check_output("mthi.hi", hi, hi_m);

        run_op("mt_with_start", 2'b01, 32'h0001_0003, 32'h0002_0005, 1'b0, 1'b1);
        run_op("disturb", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        step();
        check_output("no_requeue.busy", 32'(busy), 32'd0);
        check_output("no_requeue.done", 32'(done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            o = 2'($urandom_range(0, 3));
            if (i % 5 == 0) b = 32'd0;
            if (i % 7 == 3) b = 32'($urandom_range(1, 16));
            if (i % 11 == 6) a = 32'h8000_0000;
            run_op($sformatf("rand%0d", i), o, a, b, 1'b0, 1'b0);
        end

        apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        start = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        check_output("abort.busy", 32'(busy), 32'd0);
        check_output("abort.done", 32'(done), 32'd0);
        check_output("abort.hi", hi, 32'd0);
        check_output("abort.lo", lo, 32'd0);
        reset     = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        check_output("abort.no_done", 32'(seen_done), 32'd0);
        check_output("abort.idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
